// File: rtl/rgb_yuv.sv
// RGB to BT.601 full-range YUV converter, 4 pixels per clock, with sync carried
// alongside the data and optional 4:2:2 chroma averaging / blanking fill.
module rgb_yuv #(
  parameter int CHROMA_422 = 0,
  parameter int BLANK_FILL = 1
) (
  input  logic        vid_clk,
  input  logic        vid_rst_n,
  input  logic [31:0] RGB_R,
  input  logic [31:0] RGB_G,
  input  logic [31:0] RGB_B,
  input  logic        TPG_HS,
  input  logic        TPG_VS,
  input  logic        TPG_DE,
  output logic        HS,
  output logic        VS,
  output logic        DE,
  output logic [31:0] Y,
  output logic [31:0] U,
  output logic [31:0] V,
  output logic [95:0] data_yuv
);

  localparam int LAT = (CHROMA_422 != 0) ? 4 : 3;

  logic [16:0] p_yr [4];
  logic [16:0] p_yg [4];
  logic [16:0] p_yb [4];
  logic [16:0] p_ur [4];
  logic [16:0] p_ug [4];
  logic [16:0] p_ub [4];
  logic [16:0] p_vr [4];
  logic [16:0] p_vg [4];
  logic [16:0] p_vb [4];

  logic [19:0] s_y [4];
  logic [19:0] s_u [4];
  logic [19:0] s_v [4];

  logic [LAT-1:0] hs_sr, vs_sr, de_sr;
  logic [31:0]    y_q, u_q, v_q;
  logic           blank;

  function automatic logic [7:0] clamp8(input logic [19:0] s);
    if (s[19])            return 8'h00;
    else if (|s[18:17])   return 8'hFF;
    else                  return s[16:9];
  endfunction

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    t = {1'b0, a} + {1'b0, b} + 9'd1;
    return t[8:1];
  endfunction

  // Blanking looks at the DE bit that moves into the last sync stage on this edge
  assign blank = (BLANK_FILL != 0) && !de_sr[LAT-2];

  always_ff @(posedge vid_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!vid_rst_n) begin
        p_yr[i] <= '0; p_yg[i] <= '0; p_yb[i] <= '0;
        p_ur[i] <= '0; p_ug[i] <= '0; p_ub[i] <= '0;
        p_vr[i] <= '0; p_vg[i] <= '0; p_vb[i] <= '0;
      end else begin
        p_yr[i] <= 17'(RGB_R[8*i +: 8]) * 17'd153;
        p_yg[i] <= 17'(RGB_G[8*i +: 8]) * 17'd301;
        p_yb[i] <= 17'(RGB_B[8*i +: 8]) * 17'd58;
        p_ur[i] <= 17'(RGB_R[8*i +: 8]) * 17'd86;
        p_ug[i] <= 17'(RGB_G[8*i +: 8]) * 17'd170;
        p_ub[i] <= 17'(RGB_B[8*i +: 8]) * 17'd256;
        p_vr[i] <= 17'(RGB_R[8*i +: 8]) * 17'd256;
        p_vg[i] <= 17'(RGB_G[8*i +: 8]) * 17'd214;
        p_vb[i] <= 17'(RGB_B[8*i +: 8]) * 17'd42;
      end
    end
  end

  // Sums wrap modulo 2^20, so bit 19 is the sign of the true result
  always_ff @(posedge vid_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!vid_rst_n) begin
        s_y[i] <= '0;
        s_u[i] <= '0;
        s_v[i] <= '0;
      end else begin
        s_y[i] <= 20'(p_yr[i]) + 20'(p_yg[i]) + 20'(p_yb[i]) + 20'd256;
        s_u[i] <= 20'(p_ub[i]) - 20'(p_ur[i]) - 20'(p_ug[i]) + 20'd65792;
        s_v[i] <= 20'(p_vr[i]) - 20'(p_vg[i]) - 20'(p_vb[i]) + 20'd65792;
      end
    end
  end

  generate
    if (CHROMA_422 == 0) begin : g_444
      always_ff @(posedge vid_clk) begin
        if (!vid_rst_n) begin
          y_q <= '0;
          u_q <= '0;
          v_q <= '0;
        end else begin
          for (int i = 0; i < 4; i++) begin
            y_q[8*i +: 8] <= blank ? 8'h00 : clamp8(s_y[i]);
            u_q[8*i +: 8] <= blank ? 8'h80 : clamp8(s_u[i]);
            v_q[8*i +: 8] <= blank ? 8'h80 : clamp8(s_v[i]);
          end
        end
      end
    end else begin : g_422
      logic [31:0] c_y, c_u, c_v;

      always_ff @(posedge vid_clk) begin
        if (!vid_rst_n) begin
          c_y <= '0;
          c_u <= '0;
          c_v <= '0;
        end else begin
          for (int i = 0; i < 4; i++) begin
            c_y[8*i +: 8] <= clamp8(s_y[i]);
            c_u[8*i +: 8] <= clamp8(s_u[i]);
            c_v[8*i +: 8] <= clamp8(s_v[i]);
          end
        end
      end

      // Each chroma pair (0,1) and (2,3) shares one rounded average
      always_ff @(posedge vid_clk) begin
        if (!vid_rst_n) begin
          y_q <= '0;
          u_q <= '0;
          v_q <= '0;
        end else begin
          y_q <= blank ? 32'h0 : c_y;
          for (int p = 0; p < 2; p++) begin
            u_q[16*p +: 16] <= blank ? 16'h8080 :
                               {2{avg8(c_u[16*p +: 8], c_u[16*p+8 +: 8])}};
            v_q[16*p +: 16] <= blank ? 16'h8080 :
                               {2{avg8(c_v[16*p +: 8], c_v[16*p+8 +: 8])}};
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge vid_clk) begin
    if (!vid_rst_n) begin
      hs_sr <= '0;
      vs_sr <= '0;
      de_sr <= '0;
    end else begin
      hs_sr <= {hs_sr[LAT-2:0], TPG_HS};
      vs_sr <= {vs_sr[LAT-2:0], TPG_VS};
      de_sr <= {de_sr[LAT-2:0], TPG_DE};
    end
  end

  assign HS = hs_sr[LAT-1];
  assign VS = vs_sr[LAT-1];
  assign DE = de_sr[LAT-1];
  assign Y  = y_q;
  assign U  = u_q;
  assign V  = v_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pack
      assign data_yuv[24*gi +: 24] = {y_q[8*gi +: 8], u_q[8*gi +: 8], v_q[8*gi +: 8]};
    end
  endgenerate

endmodule

// File: tb/tb_rgb_yuv.sv
// Bench for rgb_yuv: a 4:4:4 and a 4:2:2 instance share the stimulus; each has
// its own queue of expected outputs built from the conversion formula.
module tb_rgb_yuv;

  logic        vid_clk = 1'b0;
  logic        vid_rst_n;
  logic [31:0] rgb_r, rgb_g, rgb_b;
  logic        tpg_hs, tpg_vs, tpg_de;

  logic        hs0, vs0, de0, hs1, vs1, de1;
  logic [31:0] y0, u0, v0, y1, u1, v1;
  logic [95:0] dy0, dy1;

  always #5 vid_clk = ~vid_clk;

  rgb_yuv #(.CHROMA_422(0), .BLANK_FILL(1)) dut0 (
    .vid_clk(vid_clk), .vid_rst_n(vid_rst_n),
    .RGB_R(rgb_r), .RGB_G(rgb_g), .RGB_B(rgb_b),
    .TPG_HS(tpg_hs), .TPG_VS(tpg_vs), .TPG_DE(tpg_de),
    .HS(hs0), .VS(vs0), .DE(de0), .Y(y0), .U(u0), .V(v0), .data_yuv(dy0)
  );

  rgb_yuv #(.CHROMA_422(1), .BLANK_FILL(1)) dut1 (
    .vid_clk(vid_clk), .vid_rst_n(vid_rst_n),
    .RGB_R(rgb_r), .RGB_G(rgb_g), .RGB_B(rgb_b),
    .TPG_HS(tpg_hs), .TPG_VS(tpg_vs), .TPG_DE(tpg_de),
    .HS(hs1), .VS(vs1), .DE(de1), .Y(y1), .U(u1), .V(v1), .data_yuv(dy1)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [31:0] y;
    logic [31:0] u;
    logic [31:0] v;
  } exp_t;

  localparam exp_t BLANK_E = {3'b000, 32'h0, 32'h80808080, 32'h80808080};

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_s(input int s);
    if (s < 0) return 0;
    if ((s / 512) > 255) return 255;
    return s / 512;
  endfunction

  function automatic exp_t model(input int chroma);
    exp_t m;
    int   r, g, b, a;
    int   yy[4], uu[4], vv[4];
    for (int i = 0; i < 4; i++) begin
      r = int'(rgb_r[8*i +: 8]);
      g = int'(rgb_g[8*i +: 8]);
      b = int'(rgb_b[8*i +: 8]);
      yy[i] = clamp_s(153*r + 301*g + 58*b + 256);
      uu[i] = clamp_s(256*b - 86*r - 170*g + 65792);
      vv[i] = clamp_s(256*r - 214*g - 42*b + 65792);
    end
    if (chroma != 0) begin
      for (int p = 0; p < 4; p += 2) begin
        a = (uu[p] + uu[p+1] + 1) / 2;
        uu[p] = a; uu[p+1] = a;
        a = (vv[p] + vv[p+1] + 1) / 2;
        vv[p] = a; vv[p+1] = a;
      end
    end
    m.hs = tpg_hs;
    m.vs = tpg_vs;
    m.de = tpg_de;
    for (int i = 0; i < 4; i++) begin
      m.y[8*i +: 8] = tpg_de ? 8'(yy[i]) : 8'h00;
      m.u[8*i +: 8] = tpg_de ? 8'(uu[i]) : 8'h80;
      m.v[8*i +: 8] = tpg_de ? 8'(vv[i]) : 8'h80;
    end
    return m;
  endfunction

  function automatic logic [95:0] pack(input exp_t e);
    logic [95:0] d;
    for (int i = 0; i < 4; i++)
      d[24*i +: 24] = {e.y[8*i +: 8], e.u[8*i +: 8], e.v[8*i +: 8]};
    return d;
  endfunction

  // One clock: update both scoreboards from the sampled inputs, then compare
  task automatic step();
    @(posedge vid_clk);
    if (!vid_rst_n) begin
      q0.delete();
      q1.delete();
      repeat (2) q0.push_back(BLANK_E);
      repeat (3) q1.push_back(BLANK_E);
      e0 = '0;
      e1 = '0;
    end else begin
      q0.push_back(model(0));
      q1.push_back(model(1));
      e0 = q0.pop_front();
      e1 = q1.pop_front();
    end
    #1;
    chk("d0_sync", {hs0, vs0, de0}, {e0.hs, e0.vs, e0.de});
    chk("d0_y", y0, e0.y);
    chk("d0_u", u0, e0.u);
    chk("d0_v", v0, e0.v);
    chk("d0_pack", dy0, pack(e0));
    chk("d1_sync", {hs1, vs1, de1}, {e1.hs, e1.vs, e1.de});
    chk("d1_y", y1, e1.y);
    chk("d1_u", u1, e1.u);
    chk("d1_v", v1, e1.v);
    chk("d1_pack", dy1, pack(e1));
  endtask

  initial begin
    logic [7:0] hs_pat, vs_pat, de_pat;
    vid_rst_n = 1'b0;
    rgb_r = '0; rgb_g = '0; rgb_b = '0;
    tpg_hs = 1'b0; tpg_vs = 1'b0; tpg_de = 1'b0;
    repeat (3) step();
    chk("reset_out0", {hs0, vs0, de0, y0, u0, v0}, '0);
    chk("reset_out1", {hs1, vs1, de1, y1, u1, v1}, '0);
    vid_rst_n = 1'b1;

    rgb_r = 32'hFFFFFFFF; rgb_g = 32'hFFFFFFFF; rgb_b = 32'hFFFFFFFF;
    tpg_de = 1'b1;
    repeat (6) step();
    chk("white_y0", y0, 32'hFFFFFFFF);
    chk("white_u0", u0, 32'h80808080);
    chk("white_v0", v0, 32'h80808080);
    chk("white_de0", de0, 1'b1);
    chk("white_u1", u1, 32'h80808080);

    // lanes 0..3: black, red, blue, green
    rgb_r = 32'h0000FF00; rgb_g = 32'hFF000000; rgb_b = 32'h00FF0000;
    repeat (6) step();
    chk("prim_y", y0, 32'h961D4C00);
    chk("prim_u", u0, 32'h2BFF5580);
    chk("prim_v", v0, 32'h156BFF80);

    // red next to blue for the 4:2:2 pair average
    rgb_r = 32'h000000FF; rgb_g = 32'h00000000; rgb_b = 32'h0000FF00;
    repeat (6) step();
    chk("c422_y", y1, 32'h00001D4C);
    chk("c422_u", u1, 32'h8080AAAA);
    chk("c422_v", v1, 32'h8080B5B5);

    rgb_r = 32'hFFFFFFFF; rgb_g = 32'hFFFFFFFF; rgb_b = 32'hFFFFFFFF;
    hs_pat = 8'b0000_0001;
    vs_pat = 8'b0001_1111;
    de_pat = 8'b0000_1101;
    for (int k = 0; k < 8; k++) begin
      tpg_hs = hs_pat[k];
      tpg_vs = vs_pat[k];
      tpg_de = de_pat[k];
      step();
    end
    tpg_hs = 1'b0; tpg_vs = 1'b0; tpg_de = 1'b1;
    repeat (6) step();

    repeat (3) step();
    vid_rst_n = 1'b0;
    step();
    chk("rst_mid_d0", {de0, y0, u0, v0}, '0);
    chk("rst_mid_d1", {de1, y1, u1, v1}, '0);
    step();
    vid_rst_n = 1'b1;
    step();
    chk("rst_rel_blank", {de0, y0, u0, v0}, {1'b0, 32'h0, 32'h80808080, 32'h80808080});
    repeat (5) step();
    chk("rst_resume_y", y0, 32'hFFFFFFFF);

    for (int k = 0; k < 10000; k++) begin
      rgb_r = $urandom;
      rgb_g = $urandom;
      rgb_b = $urandom;
      tpg_hs = 1'($urandom_range(0, 1));
      tpg_vs = 1'($urandom_range(0, 1));
      tpg_de = ($urandom_range(0, 7) != 0);
      vid_rst_n = ($urandom_range(0, 999) != 0);
      step();
    end
    vid_rst_n = 1'b1;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
